serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits, legal range 1 to 64.
REQ-002 SHALL have parameter DIGIT, default 1: bits added per cycle; WIDTH % DIGIT != 0 is an elaboration error.
REQ-003 SHALL have one clock and one reset: clk, input, 1 bit, the single clock for all state, rising edge.
REQ-004 SHALL have rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have in_valid, input, 1 bit: operands present.
REQ-006 SHALL have in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have a and b, inputs, WIDTH bits each: unsigned operands.
REQ-008 SHALL have carry_in, input, 1 bit: carry into bit 0.
REQ-009 SHALL have out_valid, output, 1 bit: result available.
REQ-010 SHALL have out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have sum, output, WIDTH bits: a + b + carry_in modulo 2^WIDTH.
REQ-012 SHALL have carry_out, output, 1 bit: bit WIDTH of a + b + carry_in.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-014 SHALL accept on a rising edge with in_valid && in_ready: capture a, b and carry_in; clear the digit counter; go to RUN.
REQ-015 SHALL, in each RUN cycle, add the DIGIT least-significant unprocessed bits of a and b plus the running carry, shift the digit result into sum from the MSB end, and update the running carry.
REQ-016 SHALL run N = WIDTH/DIGIT RUN cycles: out_valid rises exactly N clock edges after the accepting edge.
REQ-017 SHALL, with WIDTH == DIGIT, execute one RUN cycle (N = 1).
REQ-018 SHALL ignore a, b, carry_in and in_valid while in RUN or DONE; the captured operands are not affected.
REQ-019 SHALL hold sum and carry_out stable in DONE until out_valid && out_ready.
REQ-020 SHALL return from DONE to IDLE on out_valid && out_ready; in_ready rises the following cycle, with no same-cycle accept, so the minimum issue interval is N+2 cycles.
REQ-021 SHALL return sum and carry_out to 0 on leaving DONE and keep them 0 in IDLE.
REQ-022 SHALL ignore out_ready outside DONE.
REQ-023 SHALL decode an unreachable state encoding to IDLE on the next edge.
REQ-024 SHALL compute the results exactly: a=all-ones, b=0, carry_in=1 gives sum=0 and carry_out=1.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, counter=0, operand registers=0, running carry=0, sum=0, carry_out=0, out_valid=0 and in_ready=1, independent of clk.
REQ-026 SHALL abort an operation in progress when rst_n asserts mid-RUN or in DONE; the partial result is discarded and never presented.
REQ-027 SHALL allow the first accept on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro SERIAL_ADDER_OVF_EN defined, add output overflow (1 bit) = signed two's-complement overflow of a + b + carry_in, valid and held under the same rules as sum, and 0 otherwise.
REQ-029 SHALL, without SERIAL_ADDER_OVF_EN, have no overflow port and no related logic; all other behaviour is identical.

Structure
REQ-030 SHALL put in shared package serial_adder_pkg: the state typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and a counter-width function clog2-based on WIDTH/DIGIT.
REQ-031 SHALL instantiate one combinational sub-module fa_digit (DIGIT-bit ripple adder: x, y, ci -> s, co); serial_adder holds all sequential state.

Verification
REQ-032 SHALL check WIDTH=8, DIGIT=1, a=0xFF, b=0x01, carry_in=0 -> out_valid 8 edges after accept, sum=0x00, carry_out=1.
REQ-033 SHALL check WIDTH=8, DIGIT=4, a=0x3C, b=0x45, carry_in=1 -> out_valid 2 edges after accept, sum=0x82, carry_out=0; with SERIAL_ADDER_OVF_EN, overflow=1.
REQ-034 SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> sum and carry_out unchanged, in_ready=0 throughout, then IDLE one cycle after out_ready=1.
REQ-035 SHALL check reset abort: rst_n pulsed low after 3 RUN cycles -> out_valid=0, sum=0 and in_ready=1 immediately, and the next operation a=0x10, b=0x20 gives sum=0x30.
REQ-036 SHALL check operand isolation: a and b changed randomly every cycle during RUN -> the result matches the operands captured at accept.
REQ-037 SHALL check exhaustively at WIDTH=2, DIGIT=1 all 32 (a, b, carry_in) combinations against a behavioural a+b+carry_in model.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder shared types: FSM state encoding and counter sizing.
// Optional feature macro: SERIAL_ADDER_OVF_EN (see serial_adder.sv).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_w(int width, int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// fa_digit: combinational DIGIT-bit ripple-carry adder slice.
// Used by serial_adder once per RUN cycle.
module fa_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, DIGIT bits per cycle, valid/ready.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_w(WIDTH, DIGIT);

  if (WIDTH < 1 || WIDTH > 64 || DIGIT < 1 ||
      DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: illegal WIDTH/DIGIT");
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] ds_ext;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             co_q;
  logic [DIGIT-1:0] ds;
  logic             dco;
  logic             last;
  logic             acc;
  logic             run;
  logic             fin;

  fa_digit #(.DIGIT(DIGIT)) u_fa (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .ci (cy_q),
    .s  (ds),
    .co (dco)
  );

  assign last = (cnt_q == CW'(N - 1));
  assign acc  = in_valid && (state_q == IDLE);
  assign run  = (state_q == RUN);
  assign fin  = out_ready && (state_q == DONE);

  // Each digit enters at the MSB end, so after N cycles bit 0 is at bit 0.
  assign ds_ext  = WIDTH'(ds);
  assign sum_nxt = (sum_q >> DIGIT) | (ds_ext << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      cy_q  <= 1'b0;
      co_q  <= 1'b0;
    end else if (acc) begin
      a_q   <= a;
      b_q   <= b;
      sum_q <= '0;
      cnt_q <= '0;
      cy_q  <= carry_in;
      co_q  <= 1'b0;
    end else if (run) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      sum_q <= sum_nxt;
      cnt_q <= cnt_q + CW'(1);
      cy_q  <= dco;
      if (last) co_q <= dco;
    end else if (fin) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end
  end

  assign sum       = out_valid ? sum_q : '0;
  assign carry_out = out_valid & co_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic am_q;
  logic bm_q;
  logic ovf_q;

  // Signed overflow: operands agree in sign, result MSB disagrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (acc) begin
      am_q  <= a[WIDTH-1];
      bm_q  <= b[WIDTH-1];
      ovf_q <= 1'b0;
    end else if (run && last) begin
      ovf_q <= (am_q == bm_q) && (ds[DIGIT-1] != am_q);
    end else if (fin) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = out_valid & ovf_q;
`endif

endmodule
